fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one outstanding memory read, DEPTH-entry FIFO of {instr, pc}.
// Define FETCH_QUEUE_STATS_EN to add the saturating stall_cnt output.
module fetch_queue #(
  parameter int unsigned        ADDR_W   = 15,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StWait, StDiscard} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [ADDR_W-1:0] pc_d [DEPTH];
  logic              push;
  logic              pop;

  assign instr_valid = (count_q != '0);
  assign instr       = data_q[head_q];
  assign instr_pc    = pc_q[head_q];
  assign mem_addr    = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    data_d     = data_q;
    pc_d       = pc_q;
    mem_req    = 1'b0;
    push       = 1'b0;

    unique case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (!redirect && (count_q < DepthCnt)) begin
          mem_req    = 1'b1;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        // A response landing in the redirect cycle is consumed here, so no discard is owed.
        if (mem_rvalid) begin
          push    = !redirect;
          state_d = StRun;
        end else if (redirect) begin
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (mem_rvalid) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

    pop = instr_valid && instr_ready && !redirect;

    if (push) begin
      data_d[tail_q] = mem_rdata;
      pc_d[tail_q]   = req_pc_q;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (redirect) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts starved cycles; deliberately untouched by redirect.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != StIdle) && !instr_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
